// File: rtl/vrf_bram2axi_wr_datamover_if.sv
// AXI4 write-channel bundle for the VRF BRAM-to-DDR4 store datamover.
// master drives AW/W and bready; slave drives the ready/response side.
interface vrf_bram2axi_wr_datamover_if #(
  parameter int AXI_ADDRWIDTH = 36,
  parameter int DATAWIDTH     = 1024
);
  localparam int BPB = DATAWIDTH / 8;

  logic [AXI_ADDRWIDTH-1:0] m_axi_awaddr;
  logic [1:0]               m_axi_awburst;
  logic [3:0]               m_axi_awcache;
  logic [7:0]               m_axi_awlen;
  logic                     m_axi_awlock;
  logic [2:0]               m_axi_awprot;
  logic [2:0]               m_axi_awsize;
  logic                     m_axi_awvalid;
  logic                     m_axi_awready;
  logic [DATAWIDTH-1:0]     m_axi_wdata;
  logic [BPB-1:0]           m_axi_wstrb;
  logic                     m_axi_wlast;
  logic                     m_axi_wvalid;
  logic                     m_axi_wready;
  logic [1:0]               m_axi_bresp;
  logic                     m_axi_bvalid;
  logic                     m_axi_bready;

  modport master (
    output m_axi_awaddr, m_axi_awburst, m_axi_awcache, m_axi_awlen,
    output m_axi_awlock, m_axi_awprot, m_axi_awsize, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awburst, m_axi_awcache, m_axi_awlen,
    input  m_axi_awlock, m_axi_awprot, m_axi_awsize, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/vrf_bram2axi_wr_datamover.sv
// Reads consecutive VRF staging-BRAM words and writes them to DDR4 as
// AXI4 INCR bursts split at 4 KB; ports: start/done/error, BRAM read, axi.
module vrf_bram2axi_wr_datamover #(
  parameter int AXI_ADDRWIDTH  = 36,
  parameter int BRAM_ADDRWIDTH = 10,
  parameter int DATAWIDTH      = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [BRAM_ADDRWIDTH-1:0] src_bram_addr_i,
  input  logic [AXI_ADDRWIDTH-1:0]  dst_axi_addr_i,
  input  logic [14:0]               byte_to_trans_i,
  output logic                      done_o,
  output logic                      error_o,
  output logic [BRAM_ADDRWIDTH-1:0] bram_addr,
  output logic                      bram_en,
  input  logic [DATAWIDTH-1:0]      bram_rddata,
  vrf_bram2axi_wr_datamover_if.master axi
);
  localparam int BPB = DATAWIDTH / 8;
  localparam int SZ  = $clog2(BPB);
  localparam logic [AXI_ADDRWIDTH-1:0] AMASK = AXI_ADDRWIDTH'(BPB - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_AW    = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_BRESP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]               state;
  logic [AXI_ADDRWIDTH-1:0] addr;
  logic [15:0]              beats_left;
  logic [8:0]               blen;
  logic [8:0]               fetch_left;
  logic [8:0]               sent;
  logic                     last_burst;
  logic [SZ-1:0]            rbytes;
  logic [BRAM_ADDRWIDTH-1:0] baddr;
  logic                     inflight;
  logic [DATAWIDTH-1:0]     mem [2];
  logic                     wptr;
  logic                     rptr;
  logic [1:0]               cnt;
  logic                     err;

  logic [15:0] n_beats;
  logic [15:0] bnd_c;
  logic [15:0] len_c;
  logic [2:0]  occ;
  logic        wvalid;
  logic        wlast;
  logic        pop;

  assign n_beats = ({1'b0, byte_to_trans_i} + 16'(BPB - 1)) >> SZ;

  // Burst length from the current cursor: capped by the 4 KB page end
  // and by the AXI4 maximum of 256 beats.
  always_comb begin
    bnd_c = (16'd4096 - {4'd0, addr[11:0]}) >> SZ;
    len_c = beats_left;
    if (bnd_c < len_c) len_c = bnd_c;
    if (len_c > 16'd256) len_c = 16'd256;
  end

  assign wvalid = (state == S_WDATA) && (cnt != 2'd0);
  assign pop    = wvalid && axi.m_axi_wready;
  assign wlast  = (sent == blen - 9'd1);

  // Occupancy after this cycle's pop, so a slot freed by the current
  // beat can be refilled immediately for back-to-back beats.
  assign occ = {1'b0, cnt} - {2'd0, pop} + {2'd0, inflight};
  assign bram_en = (state == S_WDATA) && (fetch_left != 9'd0)
                && (occ < 3'd2);
  assign bram_addr = baddr;

  assign done_o  = (state == S_DONE);
  assign error_o = err;

  assign axi.m_axi_awaddr  = addr;
  assign axi.m_axi_awburst = 2'b01;
  assign axi.m_axi_awcache = 4'b0011;
  assign axi.m_axi_awlen   = 8'(len_c - 16'd1);
  assign axi.m_axi_awlock  = 1'b0;
  assign axi.m_axi_awprot  = 3'b000;
  assign axi.m_axi_awsize  = 3'(SZ);
  assign axi.m_axi_awvalid = (state == S_AW);
  assign axi.m_axi_wdata   = mem[rptr];
  assign axi.m_axi_wlast   = wlast;
  assign axi.m_axi_wvalid  = wvalid;
  assign axi.m_axi_bready  = (state == S_BRESP);

  // Partial strobe only on the job's very last beat.
  always_comb begin
    axi.m_axi_wstrb = '1;
    if (last_burst && wlast && (rbytes != '0)) begin
      for (int i = 0; i < BPB; i++) begin
        axi.m_axi_wstrb[i] = (32'(i) < 32'(rbytes));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) mem[wptr] <= bram_rddata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      beats_left <= '0;
      blen       <= '0;
      fetch_left <= '0;
      sent       <= '0;
      last_burst <= 1'b0;
      rbytes     <= '0;
      baddr      <= '0;
      inflight   <= 1'b0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      cnt        <= 2'd0;
      err        <= 1'b0;
    end else begin
      inflight <= bram_en;
      if (bram_en) begin
        baddr      <= baddr + 1'b1;
        fetch_left <= fetch_left - 9'd1;
      end
      if (inflight) wptr <= ~wptr;
      if (pop) begin
        rptr <= ~rptr;
        sent <= sent + 9'd1;
      end
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};

      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            addr       <= dst_axi_addr_i & ~AMASK;
            beats_left <= n_beats;
            rbytes     <= byte_to_trans_i[SZ-1:0];
            baddr      <= src_bram_addr_i;
            err        <= 1'b0;
            state      <= (n_beats == 16'd0) ? S_DONE : S_AW;
          end
        end
        S_AW: begin
          if (axi.m_axi_awready) begin
            addr       <= addr + (AXI_ADDRWIDTH'(len_c) << SZ);
            beats_left <= beats_left - len_c;
            blen       <= len_c[8:0];
            fetch_left <= len_c[8:0];
            sent       <= 9'd0;
            last_burst <= (beats_left == len_c);
            state      <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (pop && wlast) state <= S_BRESP;
        end
        S_BRESP: begin
          if (axi.m_axi_bvalid) begin
            if (axi.m_axi_bresp != 2'b00) err <= 1'b1;
            state <= (beats_left != 16'd0) ? S_AW : S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vrf_bram2axi_wr_datamover.sv
// Directed bench for the BRAM-to-AXI write datamover (DATAWIDTH=1024).
// BRAM and AXI slave are behavioural; checks use immediate assertions.
module tb_vrf_bram2axi_wr_datamover;
  localparam int AW = 36;
  localparam int BW = 10;
  localparam int DW = 1024;

  logic          clk = 0;
  logic          rst = 1;
  logic          start_i = 0;
  logic [BW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [14:0]   bytes = '0;
  logic          done_o, error_o, bram_en;
  logic [BW-1:0] bram_addr;
  logic [DW-1:0] bram_rddata = '0;

  vrf_bram2axi_wr_datamover_if #(.AXI_ADDRWIDTH(AW), .DATAWIDTH(DW)) axi();

  vrf_bram2axi_wr_datamover #(
    .AXI_ADDRWIDTH(AW), .BRAM_ADDRWIDTH(BW), .DATAWIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .src_bram_addr_i(src), .dst_axi_addr_i(dst),
    .byte_to_trans_i(bytes), .done_o(done_o), .error_o(error_o),
    .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_rddata(bram_rddata), .axi(axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic [DW-1:0] pat(input logic [BW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++)
      r[i*32 +: 32] = 32'hD000_0000 ^ ({22'd0, a} * 32'h0101_0101) ^ i;
    return r;
  endfunction

  always @(posedge clk) if (bram_en) bram_rddata <= pat(bram_addr);

  logic [AW-1:0]  aw_addr_q[$];
  logic [7:0]     aw_len_q[$];
  logic [DW-1:0]  w_data_q[$];
  logic [127:0]   w_strb_q[$];
  logic           w_last_q[$];
  logic [2:0]     aw_size;
  int cyc = 0, wl_cnt = 0, b_cnt = 0, done_cnt = 0;
  int b_cyc = 0, done_cyc = 0, viol = 0;
  logic outstanding = 0;

  always @(posedge clk) begin
    if (rst) outstanding = 0;
    if (axi.m_axi_awvalid && axi.m_axi_awready) begin
      aw_addr_q.push_back(axi.m_axi_awaddr);
      aw_len_q.push_back(axi.m_axi_awlen);
      aw_size = axi.m_axi_awsize;
      if (outstanding) viol++;
      outstanding = 1;
    end
    if (axi.m_axi_wvalid && axi.m_axi_wready) begin
      w_data_q.push_back(axi.m_axi_wdata);
      w_strb_q.push_back(axi.m_axi_wstrb);
      w_last_q.push_back(axi.m_axi_wlast);
      if (axi.m_axi_wlast) wl_cnt++;
    end
    if (axi.m_axi_bvalid && axi.m_axi_bready) begin
      b_cnt++;
      b_cyc = cyc;
      outstanding = 0;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  end

  logic rnd = 0;
  int   err_idx = -1;
  int   b_base = 0;
  int   b_seen = 0;

  initial begin
    axi.m_axi_awready = 0;
    axi.m_axi_wready = 0;
    axi.m_axi_bvalid = 0;
    axi.m_axi_bresp = 2'b00;
  end

  always @(negedge clk) begin
    axi.m_axi_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    axi.m_axi_wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (b_cnt != b_seen) begin
      axi.m_axi_bvalid = 0;
      b_seen = b_cnt;
    end
    if (!axi.m_axi_bvalid && (wl_cnt > b_cnt)
        && (!rnd || $urandom_range(0, 1) == 1)) begin
      axi.m_axi_bvalid = 1;
      axi.m_axi_bresp = (b_cnt - b_base == err_idx) ? 2'b10 : 2'b00;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int dc0;

  task automatic run_job(input string tag, input logic [BW-1:0] s,
                         input logic [AW-1:0] d, input logic [14:0] n);
    logic got;
    aw_addr_q.delete();
    aw_len_q.delete();
    w_data_q.delete();
    w_strb_q.delete();
    w_last_q.delete();
    b_base = b_cnt;
    dc0 = done_cnt;
    @(negedge clk);
    src = s;
    dst = d;
    bytes = n;
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    got = 0;
    for (int i = 0; i < 20000; i++) begin
      if (done_o) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, {127'd0, got}, 128'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, 128'(done_cnt - dc0), 128'd1);
  endtask

  task automatic chk_data(input string tag, input logic [BW-1:0] s,
                          input int nb);
    int bad;
    logic [BW-1:0] a;
    bad = 0;
    a = s;
    chk({tag, "_beats"}, 128'(w_data_q.size()), 128'(nb));
    for (int k = 0; k < w_data_q.size(); k++) begin
      if (w_data_q[k] !== pat(a)) bad++;
      a = a + 1'b1;
    end
    chk({tag, "_data"}, 128'(bad), 128'd0);
  endtask

  logic [127:0] ones;
  logic [127:0] m;
  int bad;

  initial begin
    ones = '1;
    repeat (3) @(negedge clk);
    chk("reset_outs",
        {122'd0, axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready,
         bram_en, done_o, error_o}, 128'd0);
    rst = 0;

    run_job("j1", 10'h010, 36'h0, 15'd256);
    chk("j1_aw_cnt", 128'(aw_addr_q.size()), 128'd1);
    chk("j1_awaddr", 128'(aw_addr_q[0]), 128'h0);
    chk("j1_awlen", 128'(aw_len_q[0]), 128'd1);
    chk("j1_awsize", 128'(aw_size), 128'd7);
    chk_data("j1", 10'h010, 2);
    chk("j1_strb0", w_strb_q[0], ones);
    chk("j1_strb1", w_strb_q[1], ones);
    chk("j1_wlast", {126'd0, w_last_q[0], w_last_q[1]}, 128'b01);
    chk("j1_done_lat", 128'(done_cyc - b_cyc), 128'd1);
    chk("j1_error", {127'd0, error_o}, 128'd0);

    run_job("j2", 10'h020, 36'h2000, 15'd200);
    chk("j2_awlen", 128'(aw_len_q[0]), 128'd1);
    chk_data("j2", 10'h020, 2);
    chk("j2_strb0", w_strb_q[0], ones);
    m = ones >> 56;
    chk("j2_strb1", w_strb_q[1], m);

    run_job("j3", 10'h100, 36'hF80, 15'd512);
    chk("j3_aw_cnt", 128'(aw_addr_q.size()), 128'd2);
    chk("j3_aw0", {aw_addr_q[0], 84'd0, aw_len_q[0]},
        {36'hF80, 84'd0, 8'd0});
    chk("j3_aw1", {aw_addr_q[1], 84'd0, aw_len_q[1]},
        {36'h1000, 84'd0, 8'd2});
    chk("j3_aw_after_b", 128'(viol), 128'd0);
    chk_data("j3", 10'h100, 4);
    chk("j3_wlast", {124'd0, w_last_q[0], w_last_q[1], w_last_q[2],
        w_last_q[3]}, 128'b1001);

    run_job("j4", 10'h3F0, 36'h0, 15'd32767);
    chk("j4_aw_cnt", 128'(aw_addr_q.size()), 128'd8);
    bad = 0;
    for (int k = 0; k < aw_addr_q.size(); k++) begin
      if (aw_addr_q[k] !== 36'(k * 4096)) bad++;
      if (aw_len_q[k] !== 8'd31) bad++;
    end
    chk("j4_aw_fields", 128'(bad), 128'd0);
    chk_data("j4", 10'h3F0, 256);
    chk("j4_last_strb", w_strb_q[255], ones >> 1);
    chk("j4_strb_mid", w_strb_q[254], ones);
    chk("j4_aw_after_b", 128'(viol), 128'd0);

    rnd = 1;
    err_idx = 1;
    run_job("j5", 10'h050, 36'hF00, 15'd1000);
    chk("j5_aw0", {aw_addr_q[0], 84'd0, aw_len_q[0]},
        {36'hF00, 84'd0, 8'd1});
    chk("j5_aw1", {aw_addr_q[1], 84'd0, aw_len_q[1]},
        {36'h1000, 84'd0, 8'd5});
    chk_data("j5", 10'h050, 8);
    chk("j5_last_strb", w_strb_q[7], ones >> 24);
    chk("j5_error", {127'd0, error_o}, 128'd1);
    chk("j5_aw_after_b", 128'(viol), 128'd0);
    repeat (10) @(negedge clk);
    chk("j5_error_sticky", {127'd0, error_o}, 128'd1);
    rnd = 0;
    err_idx = -1;

    @(negedge clk);
    aw_addr_q.delete();
    dc0 = done_cnt;
    bytes = 15'd0;
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    chk("j6_done_next", {127'd0, done_o}, 128'd1);
    chk("j6_error_clr", {127'd0, error_o}, 128'd0);
    repeat (4) @(negedge clk);
    chk("j6_no_aw", 128'(aw_addr_q.size()), 128'd0);
    chk("j6_done_once", 128'(done_cnt - dc0), 128'd1);

    dc0 = done_cnt;
    src = 10'h000;
    dst = 36'h0;
    bytes = 15'd4096;
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    bad = 1;
    for (int i = 0; i < 100; i++) begin
      if (axi.m_axi_wvalid) begin
        bad = 0;
        break;
      end
      @(negedge clk);
    end
    chk("j7_wvalid_seen", 128'(bad), 128'd0);
    rst = 1;
    @(negedge clk);
    chk("j7_rst_outs",
        {122'd0, axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_bready,
         bram_en, done_o, error_o}, 128'd0);
    rst = 0;
    repeat (5) @(negedge clk);
    chk("j7_no_done", 128'(done_cnt - dc0), 128'd0);
    chk("j7_idle", {127'd0, axi.m_axi_awvalid}, 128'd0);

    run_job("j8", 10'h3FF, 36'h40080, 15'd384);
    chk("j8_aw", {aw_addr_q[0], 84'd0, aw_len_q[0]},
        {36'h40080, 84'd0, 8'd2});
    chk_data("j8", 10'h3FF, 3);
    chk("j8_error", {127'd0, error_o}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
